mixcolumns_iter: RTL and testbench

Parametrised, handshaked successor to the combinational MixColumns stage. It supports both forward MixColumns (encrypt) and InvMixColumns (decrypt), plus a per-transaction bypass for the last round. Columns are processed iteratively, COLS_PER_CYCLE at a time, so one GF(2^8) column datapath can be shared across cycles to trade area for latency. It sits between ShiftRows/InvShiftRows and AddRoundKey in the round datapath.

---
 rtl/mixcolumns_iter.sv | 139 +++++++++++++
 tb/tb_mixcolumns_iter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mixcolumns_iter.sv
// Iterative AES MixColumns/InvMixColumns with bypass, COLS_PER_CYCLE columns per busy cycle.
// Latency 4/COLS_PER_CYCLE edges after acceptance (bypass: result on acceptance edge); result held in DONE until out_ready.
module mixcolumns_iter #(
  parameter int COLS_PER_CYCLE = 1,
  parameter int NUM_COLS       = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inverse,
  input  logic         in_bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  generate
    if (NUM_COLS != 4) begin : g_bad_cols
      $fatal(1, "mixcolumns_iter: NUM_COLS must be 4");
    end
    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cpc
      $fatal(1, "mixcolumns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t       state_q, state_d;
  logic [127:0] work_q, work_d;
  logic [127:0] out_q, out_d;
  logic         inv_q, inv_d;
  logic [1:0]   col_cnt_q, col_cnt_d;
  logic [2:0]   cnt_sum;
  logic [1:0]   grp_idx;
  logic         accept;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    xtime = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c, input logic inv);
    logic [7:0] a [4];
    logic [7:0] m2 [4];
    logic [7:0] m3 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[8*i +: 8];
      m2[i] = xtime(a[i]);
      x4    = xtime(m2[i]);
      x8    = xtime(x4);
      m3[i] = m2[i] ^ a[i];
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ m2[i] ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ m2[i];
    end
    if (inv) begin
      mix_col = {mb[0] ^ md[1] ^ m9[2] ^ me[3],
                 md[0] ^ m9[1] ^ me[2] ^ mb[3],
                 m9[0] ^ me[1] ^ mb[2] ^ md[3],
                 me[0] ^ mb[1] ^ md[2] ^ m9[3]};
    end else begin
      mix_col = {m3[0] ^ a[1]  ^ a[2]  ^ m2[3],
                 a[0]  ^ a[1]  ^ m2[2] ^ m3[3],
                 a[0]  ^ m2[1] ^ m3[2] ^ a[3],
                 m2[0] ^ m3[1] ^ a[2]  ^ a[3]};
    end
  endfunction

  assign in_ready = (state_q == IDLE) || (state_q == DONE && out_ready);
  assign accept   = in_valid && in_ready;
  // Carry out of the 2-bit counter marks the last column group.
  assign cnt_sum  = {1'b0, col_cnt_q} + 3'(COLS_PER_CYCLE);

  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    out_d     = out_q;
    inv_d     = inv_q;
    col_cnt_d = col_cnt_q;
    grp_idx   = col_cnt_q;
    case (state_q)
      BUSY: begin
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
          grp_idx = col_cnt_q + 2'(g);
          work_d[{grp_idx, 5'b0} +: 32] = mix_col(work_q[{grp_idx, 5'b0} +: 32], inv_q);
        end
        col_cnt_d = cnt_sum[1:0];
        if (cnt_sum[2]) begin
          state_d = DONE;
          out_d   = work_d;
        end
      end
      DONE: begin
        if (out_ready && !in_valid) state_d = IDLE;
      end
      default: ;
    endcase
    if (accept) begin
      work_d    = in_state;
      inv_d     = in_inverse;
      col_cnt_d = 2'd0;
      if (in_bypass) begin
        state_d = DONE;
        out_d   = in_state;
      end else begin
        state_d = BUSY;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      work_q    <= '0;
      out_q     <= '0;
      inv_q     <= 1'b0;
      col_cnt_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      out_q     <= out_d;
      inv_q     <= inv_d;
      col_cnt_q <= col_cnt_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == BUSY);
  assign out_state = out_q;

endmodule

// File: tb/tb_mixcolumns_iter.sv
// Bench for mixcolumns_iter: three instances (1, 2, 4 columns per cycle) against a GF(2^8) matrix model.
module tb_mixcolumns_iter;
  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid   [N];
  logic         in_ready   [N];
  logic [127:0] in_state   [N];
  logic         in_inverse [N];
  logic         in_bypass  [N];
  logic         out_valid  [N];
  logic         out_ready  [N];
  logic [127:0] out_state  [N];
  logic         busy       [N];

  int cpc [N] = '{1, 2, 4};

  mixcolumns_iter #(.COLS_PER_CYCLE(1), .NUM_COLS(4)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_state(in_state[0]),
    .in_inverse(in_inverse[0]), .in_bypass(in_bypass[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_state(out_state[0]), .busy(busy[0]));
  mixcolumns_iter #(.COLS_PER_CYCLE(2), .NUM_COLS(4)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_state(in_state[1]),
    .in_inverse(in_inverse[1]), .in_bypass(in_bypass[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_state(out_state[1]), .busy(busy[1]));
  mixcolumns_iter #(.COLS_PER_CYCLE(4), .NUM_COLS(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_state(in_state[2]),
    .in_inverse(in_inverse[2]), .in_bypass(in_bypass[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_state(out_state[2]), .busy(busy[2]));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Shift-and-add GF(2^8) multiply, reduction polynomial 0x11b.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    logic       hi;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      hi = aa[7];
      aa = {aa[6:0], 1'b0};
      if (hi) aa = aa ^ 8'h1b;
    end
    return p;
  endfunction

  // Circulant matrix product per column: r_i = sum_j coef[(j-i) mod 4] * a_j.
  function automatic logic [127:0] mix_state(input logic [127:0] s, input logic inv);
    logic [7:0]   cf [4];
    logic [7:0]   acc;
    logic [127:0] r;
    if (inv) begin cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09; end
    else     begin cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01; end
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(cf[(j - i + 4) % 4], s[(c*4 + j)*8 +: 8]);
        r[(c*4 + i)*8 +: 8] = acc;
      end
    end
    return r;
  endfunction

  // Transaction-level model: phase 0 idle, 1 transforming, 2 holding a result.
  int           m_phase [N] = '{default: 0};
  int           m_rem   [N] = '{default: 0};
  logic [127:0] m_out   [N] = '{default: '0};
  logic [127:0] m_res   [N] = '{default: '0};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_phase[i] = 0; m_rem[i] = 0; m_out[i] = '0; m_res[i] = '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        logic rdy, acc;
        rdy = (m_phase[i] == 0) || (m_phase[i] == 2 && out_ready[i]);
        acc = in_valid[i] && rdy;
        if (m_phase[i] == 1) begin
          m_rem[i]--;
          if (m_rem[i] == 0) begin m_phase[i] = 2; m_out[i] = m_res[i]; end
        end else if (m_phase[i] == 2 && out_ready[i]) begin
          m_phase[i] = 0;
        end
        if (acc) begin
          if (in_bypass[i]) begin
            m_phase[i] = 2; m_out[i] = in_state[i]; m_res[i] = in_state[i];
          end else begin
            m_phase[i] = 1; m_rem[i] = 4 / cpc[i]; m_res[i] = mix_state(in_state[i], in_inverse[i]);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      chk($sformatf("cyc out_valid[%0d]", i), 128'(out_valid[i]), 128'(m_phase[i] == 2));
      chk($sformatf("cyc busy[%0d]", i), 128'(busy[i]), 128'(m_phase[i] == 1));
      chk($sformatf("cyc in_ready[%0d]", i), 128'(in_ready[i]),
          128'((m_phase[i] == 0) || (m_phase[i] == 2 && out_ready[i])));
      chk($sformatf("cyc out_state[%0d]", i), out_state[i], m_out[i]);
    end
  end

  task automatic xact(input int i, input logic [127:0] s, input logic inv, input logic byp,
                      input logic [127:0] exp, input int exp_lat, input int exp_busy,
                      input string nm, output logic [127:0] got);
    int lat, bc;
    @(negedge clk); #1;
    in_state[i] = s; in_inverse[i] = inv; in_bypass[i] = byp; in_valid[i] = 1'b1; out_ready[i] = 1'b1;
    @(posedge clk); #1;
    in_valid[i] = 1'b0;
    lat = 0;
    bc  = busy[i] ? 1 : 0;
    while (!out_valid[i] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (busy[i]) bc++;
    end
    chk({nm, " latency"}, 128'(lat), 128'(exp_lat));
    if (exp_busy >= 0) chk({nm, " busy cycles"}, 128'(bc), 128'(exp_busy));
    chk({nm, " data"}, out_state[i], exp);
    got = out_state[i];
  endtask

  task automatic wait_valid(input int i, input string nm);
    int n;
    n = 0;
    while (!out_valid[i] && n < 20) begin @(posedge clk); #1; n++; end
    chk({nm, " timeout"}, 128'(out_valid[i]), 128'(1));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] a, b, c, d, got, lit_in, lit_out;
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      in_valid[i] = 1'b0; in_state[i] = '0; in_inverse[i] = 1'b0; in_bypass[i] = 1'b0; out_ready[i] = 1'b1;
    end

    // Pin the model to hand-computed vectors.
    chk("model fwd", mix_state({4{32'h455313db}}, 1'b0), {4{32'hbca14d8e}});
    lit_in  = {32'hc6c6c6c6, 32'h01010101, 32'h9d58dc9f, 32'hbca14d8e};
    lit_out = {32'hc6c6c6c6, 32'h01010101, 32'h5c220af2, 32'h455313db};
    chk("model inv", mix_state(lit_in, 1'b1), lit_out);

    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("reset out_valid[%0d]", i), 128'(out_valid[i]), 128'(0));
      chk($sformatf("reset out_state[%0d]", i), out_state[i], 128'(0));
      chk($sformatf("reset busy[%0d]", i), 128'(busy[i]), 128'(0));
    end
    #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < N; i++) chk($sformatf("post-reset in_ready[%0d]", i), 128'(in_ready[i]), 128'(1));

    xact(0, {4{32'h455313db}}, 1'b0, 1'b0, {4{32'hbca14d8e}}, 4, 4, "fwd cpc1", got);
    xact(1, lit_in, 1'b1, 1'b0, lit_out, 2, 2, "inv cpc2", got);
    xact(2, {4{32'h455313db}}, 1'b0, 1'b0, {4{32'hbca14d8e}}, 1, 1, "fwd cpc4", got);

    for (int i = 0; i < N; i++) begin
      a = {$urandom, $urandom, $urandom, $urandom};
      xact(i, a, 1'($urandom), 1'b1, a, 0, 0, $sformatf("bypass[%0d]", i), got);
    end

    // Backpressure, then simultaneous consume and accept.
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    c = {$urandom, $urandom, $urandom, $urandom};
    d = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk); #1;
    in_state[0] = a; in_inverse[0] = 1'b0; in_bypass[0] = 1'b0; in_valid[0] = 1'b1; out_ready[0] = 1'b0;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    wait_valid(0, "bp first");
    chk("bp first data", out_state[0], mix_state(a, 1'b0));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp hold valid", 128'(out_valid[0]), 128'(1));
      chk("bp hold data", out_state[0], mix_state(a, 1'b0));
      chk("bp hold in_ready", 128'(in_ready[0]), 128'(0));
    end
    #1;
    in_state[0] = b; in_inverse[0] = 1'b1; in_valid[0] = 1'b1; out_ready[0] = 1'b1;
    #1 chk("b2b in_ready", 128'(in_ready[0]), 128'(1));
    @(posedge clk); #1;
    chk("b2b no bubble busy", 128'(busy[0]), 128'(1));
    chk("b2b out_valid drop", 128'(out_valid[0]), 128'(0));
    chk("b2b in_ready busy", 128'(in_ready[0]), 128'(0));
    in_state[0] = c;
    @(posedge clk); #1;
    chk("b2b in_ready busy2", 128'(in_ready[0]), 128'(0));
    in_valid[0] = 1'b0;
    wait_valid(0, "b2b second");
    chk("b2b second data", out_state[0], mix_state(b, 1'b1));
    @(negedge clk); #1;
    in_state[0] = d; in_bypass[0] = 1'b1; in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0; in_bypass[0] = 1'b0;
    chk("b2b bypass valid", 128'(out_valid[0]), 128'(1));
    chk("b2b bypass data", out_state[0], d);

    // Reset with two columns already transformed.
    a = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk); #1;
    in_state[0] = a; in_inverse[0] = 1'b0; in_bypass[0] = 1'b0; in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst out_valid", 128'(out_valid[0]), 128'(0));
    chk("midrst out_state", out_state[0], 128'(0));
    chk("midrst busy", 128'(busy[0]), 128'(0));
    @(negedge clk); #1 rst = 1'b0;
    b = {$urandom, $urandom, $urandom, $urandom};
    xact(0, b, 1'b0, 1'b0, mix_state(b, 1'b0), 4, 4, "after reset", got);

    // Random traffic on all instances; the per-cycle compare does the checking.
    for (int k = 0; k < 400; k++) begin
      @(negedge clk); #1;
      for (int i = 0; i < N; i++) begin
        in_valid[i]   = 1'($urandom);
        in_state[i]   = {$urandom, $urandom, $urandom, $urandom};
        in_inverse[i] = 1'($urandom);
        in_bypass[i]  = ($urandom_range(3) == 0);
        out_ready[i]  = ($urandom_range(3) != 0);
      end
    end
    @(negedge clk); #1;
    for (int i = 0; i < N; i++) begin in_valid[i] = 1'b0; in_bypass[i] = 1'b0; out_ready[i] = 1'b1; end
    repeat (8) @(posedge clk);

    for (int k = 0; k < 1000; k++) begin
      a = {$urandom, $urandom, $urandom, $urandom};
      xact(2, a, 1'b0, 1'b0, mix_state(a, 1'b0), 1, -1, "rt fwd", got);
      xact(2, got, 1'b1, 1'b0, a, 1, -1, "rt inv", b);
    end

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
